stream_scrambler_wide: RTL and testbench

//   Multi-lane additive (XOR) scrambler/descrambler for the SDR byte datapath, NBYTES bytes per beat.

---
 rtl/scrambler_pkg.sv | 28 ++
 rtl/axis_skid_buf.sv | 35 +++
 rtl/stream_scrambler_wide.sv | 109 ++++++++++
 tb/tb_stream_scrambler_wide.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/scrambler_pkg.sv
// scrambler_pkg: shared LFSR helpers and tap constants for the stream scramblers
package scrambler_pkg;
  localparam int MAX_W = 16;
  localparam int MAX_STEPS = 8 * MAX_W;
  localparam logic [6:0] TAP_802_3 = 7'b1001000;
  localparam logic [14:0] TAP_DVB = 15'h6000;

  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] s, input logic [MAX_W-1:0] taps, input int w);
    logic fb;
    fb = s[0] ^ ^(s & taps);
    return (s >> 1) | (MAX_W'(fb) << (w - 1));
  endfunction

  function automatic logic [MAX_W-1:0] lfsr_advance_n(input logic [MAX_W-1:0] s, input logic [MAX_W-1:0] taps, input int w, input int n);
    logic [MAX_W-1:0] r;
    r = s;
    for (int i = 0; i < MAX_STEPS; i++)
      if (i < n) r = lfsr_step(r, taps, w);
    return r;
  endfunction

  function automatic logic [$clog2(MAX_W+1)-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [$clog2(MAX_W+1)-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_W; i++) c = c + ($clog2(MAX_W+1))'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: two-entry registered ready/valid stage; in_ready comes straight from a flop
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] skid_d;
  logic         skid_v;

  assign in_ready = !skid_v;

  // Main slot refills from skid first; skid only catches a beat while main is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_v    <= 1'b0;
      skid_d    <= '0;
    end else if (!out_valid || out_ready) begin
      out_valid <= skid_v | in_valid;
      out_data  <= skid_v ? skid_d : (in_valid ? in_data : out_data);
      skid_v    <= 1'b0;
    end else if (in_valid) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end
endmodule

// File: rtl/stream_scrambler_wide.sv
// stream_scrambler_wide: multi-lane additive AXIS scrambler with tkeep compaction, reseed and status counters
module stream_scrambler_wide
  import scrambler_pkg::*;
#(
  parameter int                NBYTES   = 4,
  parameter int                LFSR_W   = 7,
  parameter logic [LFSR_W-1:0] TAP_MASK = TAP_802_3,
  parameter int                CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [8*NBYTES-1:0] s_tdata,
  input  logic [NBYTES-1:0]   s_tkeep,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [8*NBYTES-1:0] m_tdata,
  output logic [NBYTES-1:0]   m_tkeep,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  input  logic                cfg_enable,
  input  logic                cfg_bypass,
  input  logic                cfg_frame_rsd,
  input  logic                cfg_seed_wr,
  input  logic [LFSR_W-1:0]   cfg_seed,
  output logic                running_pulse,
  output logic [CNT_W-1:0]    stat_bytes,
  output logic [CNT_W-1:0]    stat_frames
);
  localparam int DW = 8 * NBYTES;
  localparam int PW = $clog2(MAX_W + 1);

  logic [LFSR_W-1:0] lfsr, seed_q, seed_in, lfsr_adv;
  logic [MAX_W-1:0]  st;
  logic [DW-1:0]     mask, sc_data;
  logic [PW-1:0]     pc;
  logic [CNT_W:0]    bytes_sum;
  logic              en_q, buf_rdy, acc;
  int                idx;

  assign s_tready  = en_q & buf_rdy;
  assign acc       = s_tvalid & s_tready;
  assign pc        = popcount(MAX_W'(s_tkeep));
  assign seed_in   = (cfg_seed == '0) ? LFSR_W'(1) : cfg_seed;
  assign lfsr_adv  = LFSR_W'(lfsr_advance_n(MAX_W'(lfsr), MAX_W'(TAP_MASK), LFSR_W, 8 * int'(pc)));
  assign bytes_sum = {1'b0, stat_bytes} + (CNT_W+1)'(pc);

  // Unroll the LFSR across a full beat; bit j is the output of step j
  always_comb begin
    st   = MAX_W'(lfsr);
    mask = '0;
    for (int j = 0; j < DW; j++) begin
      mask[j] = st[0];
      st      = lfsr_step(st, MAX_W'(TAP_MASK), LFSR_W);
    end
  end

  // Kept lanes take mask bytes in ascending order; dropped lanes pass untouched
  always_comb begin
    sc_data = s_tdata;
    idx     = 0;
    for (int i = 0; i < NBYTES; i++) begin
      idx = int'(popcount(MAX_W'(s_tkeep) & ((MAX_W'(1) << i) - MAX_W'(1))));
      if (s_tkeep[i] && !cfg_bypass) sc_data[8*i +: 8] = s_tdata[8*i +: 8] ^ mask[8*idx +: 8];
    end
  end

  // Seed write beats frame reseed beats normal advance; bypass freezes the sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr          <= LFSR_W'(1);
      seed_q        <= LFSR_W'(1);
      en_q          <= 1'b0;
      running_pulse <= 1'b0;
    end else begin
      en_q          <= cfg_enable;
      running_pulse <= acc;
      if (cfg_seed_wr) begin
        seed_q <= seed_in;
        lfsr   <= seed_in;
      end else if (acc && !cfg_bypass) begin
        lfsr <= (s_tlast && cfg_frame_rsd) ? seed_q : lfsr_adv;
      end
    end
  end

  // Saturating byte and frame counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bytes  <= '0;
      stat_frames <= '0;
    end else if (acc) begin
      stat_bytes <= bytes_sum[CNT_W] ? '1 : bytes_sum[CNT_W-1:0];
      if (s_tlast && !(&stat_frames)) stat_frames <= stat_frames + CNT_W'(1);
    end
  end

  axis_skid_buf #(.W(DW + NBYTES + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({s_tlast, s_tkeep, sc_data}),
    .in_valid  (acc),
    .in_ready  (buf_rdy),
    .out_data  ({m_tlast, m_tkeep, m_tdata}),
    .out_valid (m_tvalid),
    .out_ready (m_tready)
  );
endmodule

// File: tb/tb_stream_scrambler_wide.sv
// tb_stream_scrambler_wide: directed checks of the scrambler against a byte-serial LFSR model
module tb_stream_scrambler_wide;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] s_tdata = '0, m_tdata, ds_m_tdata;
  logic [3:0]  s_tkeep = '0, m_tkeep, ds_m_tkeep;
  logic        s_tlast = 1'b0, s_tvalid = 1'b0, s_tready, m_tlast, m_tvalid;
  logic        ds_s_tready, ds_m_tlast, ds_m_tvalid, d_mready, ds_s_tvalid;
  logic        cfg_enable = 1'b0, cfg_bypass = 1'b0, cfg_frame_rsd = 1'b0, cfg_seed_wr = 1'b0;
  logic [6:0]  cfg_seed = 7'd1;
  logic        running_pulse, ds_running_pulse;
  logic [31:0] stat_bytes, stat_frames;
  logic [5:0]  ds_stat_bytes, ds_stat_frames;
  logic        chain = 1'b0, rnd = 1'b0, tb_mready = 1'b1;
  logic        d_stall = 1'b0, ds_stall = 1'b0;
  logic [36:0] d_hold = '0, ds_hold = '0, d_bus, ds_bus;
  logic [6:0]  ms = 7'd1, mseed = 7'd1;
  logic [36:0] outq[$], expq[$];
  int          checks = 0, errors = 0, stab_bad = 0;

  always #5 clk = ~clk;

  assign d_mready    = chain ? ds_s_tready : tb_mready;
  assign ds_s_tvalid = chain & m_tvalid;
  assign d_bus       = {m_tlast, m_tkeep, m_tdata};
  assign ds_bus      = {ds_m_tlast, ds_m_tkeep, ds_m_tdata};

  stream_scrambler_wide dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(d_mready),
    .cfg_enable(cfg_enable), .cfg_bypass(cfg_bypass), .cfg_frame_rsd(cfg_frame_rsd),
    .cfg_seed_wr(cfg_seed_wr), .cfg_seed(cfg_seed),
    .running_pulse(running_pulse), .stat_bytes(stat_bytes), .stat_frames(stat_frames)
  );

  stream_scrambler_wide #(.CNT_W(6)) dsc (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(m_tdata), .s_tkeep(m_tkeep), .s_tlast(m_tlast), .s_tvalid(ds_s_tvalid), .s_tready(ds_s_tready),
    .m_tdata(ds_m_tdata), .m_tkeep(ds_m_tkeep), .m_tlast(ds_m_tlast), .m_tvalid(ds_m_tvalid), .m_tready(tb_mready),
    .cfg_enable(cfg_enable), .cfg_bypass(cfg_bypass), .cfg_frame_rsd(cfg_frame_rsd),
    .cfg_seed_wr(cfg_seed_wr), .cfg_seed(cfg_seed),
    .running_pulse(ds_running_pulse), .stat_bytes(ds_stat_bytes), .stat_frames(ds_stat_frames)
  );

  initial forever begin
    @(posedge clk);
    #1;
    tb_mready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (chain ? (ds_m_tvalid && tb_mready) : (m_tvalid && d_mready)) outq.push_back(chain ? ds_bus : d_bus);
    stab_bad <= stab_bad + int'(ds_stall && ds_bus !== ds_hold) + int'(d_stall && d_bus !== d_hold);
    ds_stall <= ds_m_tvalid && !tb_mready;
    d_stall  <= m_tvalid && !d_mready;
    ds_hold  <= ds_bus;
    d_hold   <= d_bus;
  end

  function automatic logic [7:0] mbyte();
    logic [7:0] b;
    logic fb;
    for (int k = 0; k < 8; k++) begin
      b[k] = ms[0];
      fb   = ms[0] ^ ms[3] ^ ms[6];
      ms   = {fb, ms[6:1]};
    end
    return b;
  endfunction

  function automatic logic [36:0] model_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic [31:0] r;
    r = d;
    if (!chain && !cfg_bypass) begin
      for (int i = 0; i < 4; i++) if (k[i]) r[8*i +: 8] = d[8*i +: 8] ^ mbyte();
      if (l && cfg_frame_rsd) ms = mseed;
    end
    return {l, k, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, o, e);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic sw);
    int n;
    n = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    while (!s_tready && n < 200) begin step(); n++; end
    chk("send_ready", 64'(s_tready), 64'd1);
    if (sw) begin cfg_seed = '0; cfg_seed_wr = 1'b1; end
    expq.push_back(model_beat(d, k, l));
    step();
    s_tvalid = 1'b0; cfg_seed_wr = 1'b0;
    if (sw) begin ms = 7'd1; mseed = 7'd1; end
  endtask

  task automatic drain(input string tag);
    int n;
    logic [36:0] e, o;
    n = 0;
    while (outq.size() < expq.size() && n < 20000) begin step(); n++; end
    chk({tag, "_count"}, 64'(outq.size()), 64'(expq.size()));
    while (expq.size() > 0) begin
      e = expq.pop_front();
      o = (outq.size() > 0) ? outq.pop_front() : 'x;
      chk(tag, 64'(o), 64'(e));
    end
    outq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    outq.delete(); expq.delete();
    ms = 7'd1; mseed = 7'd1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic seed_write(input logic [6:0] sd);
    cfg_seed = sd; cfg_seed_wr = 1'b1;
    step();
    cfg_seed_wr = 1'b0;
    ms = sd; mseed = sd;
  endtask

  initial begin
    cfg_enable = 1'b1;
    repeat (3) step();
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("rst_m_side", 64'({m_tkeep, m_tlast}), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_counters", 64'({stat_bytes, stat_frames}), 64'd0);
    // Zero data with all lanes kept exposes the raw mask stream
    rst_n = 1'b1;
    step();
    chk("t1_ready_c1", 64'(s_tready), 64'd1);
    chk("t1_valid_c1", 64'(m_tvalid), 64'd0);
    send(32'h0, 4'hF, 1'b0, 1'b0);
    chk("t1_valid_c2", 64'(m_tvalid), 64'd1);
    chk("t1_pulse", 64'(running_pulse), 64'd1);
    for (int b = 0; b < 15; b++) send(32'h0, 4'hF, b == 14, 1'b0);
    chk("t1_bytes", 64'(stat_bytes), 64'd64);
    chk("t1_frames", 64'(stat_frames), 64'd1);
    step();
    chk("t1_pulse_idle", 64'(running_pulse), 64'd0);
    chk("t1_first_mask", 64'(outq[0][15:0]), 64'h9781);
    drain("t1");
    // Partial keep compacts mask bytes into the kept lanes
    seed_write(7'd1);
    send(32'h0, 4'b0011, 1'b0, 1'b0);
    send(32'h0, 4'hF, 1'b0, 1'b0);
    step();
    chk("t2_partial", 64'(outq[0][31:0]), 64'h0000_9781);
    drain("t2");
    // Seed write colliding with a beat: beat uses old state, zero seed becomes 1
    send(32'hA5A5_A5A5, 4'hF, 1'b0, 1'b1);
    send(32'h0, 4'hF, 1'b0, 1'b0);
    step();
    chk("t5_after_seed0", 64'(outq[1][15:0]), 64'h9781);
    drain("t5");
    // Bypass beats pass through and leave the mask sequence untouched
    send(32'h1234_5678, 4'hF, 1'b0, 1'b0);
    cfg_bypass = 1'b1;
    for (int b = 0; b < 4; b++) send(32'hC0DE_0000 + 32'(b), 4'hF, 1'b0, 1'b0);
    cfg_bypass = 1'b0;
    send(32'h0, 4'hF, 1'b1, 1'b0);
    drain("t6_bypass");
    cfg_enable = 1'b0;
    step();
    chk("enable_drop", 64'(s_tready), 64'd0);
    cfg_enable = 1'b1;
    step();
    // Frame reseed from 7'h55 over three frames
    do_reset();
    seed_write(7'h55);
    cfg_frame_rsd = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 5; b++) send($urandom, 4'hF, b == 4, 1'b0);
    drain("t4");
    chk("t4_frames", 64'(stat_frames), 64'd3);
    chk("t4_bytes", 64'(stat_bytes), 64'd60);
    // Scrambler into descrambler under random backpressure
    do_reset();
    chain = 1'b1; rnd = 1'b1;
    for (int b = 0; b < 1000; b++) send($urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, 1'b0);
    drain("t3_chain");
    chk("t3_stable", 64'(stab_bad), 64'd0);
    chk("t3_sat_bytes", 64'(ds_stat_bytes), 64'd63);
    chk("t3_sat_frames", 64'(ds_stat_frames), 64'd63);
    rnd = 1'b0; chain = 1'b0; cfg_frame_rsd = 1'b0;
    step(); step();
    // Reset mid-frame flushes the pipe and restarts the mask from 1
    send(32'h0, 4'hF, 1'b0, 1'b0);
    send(32'h0, 4'hF, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(m_tvalid), 64'd0);
    chk("midrst_counters", 64'({stat_bytes, stat_frames}), 64'd0);
    step();
    outq.delete(); expq.delete();
    ms = 7'd1; mseed = 7'd1;
    rst_n = 1'b1;
    step();
    send(32'h0, 4'hF, 1'b1, 1'b0);
    step();
    chk("midrst_restart", 64'(outq[0][15:0]), 64'h9781);
    drain("midrst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
